// File: rtl/noc_config_injector_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_config_injector_if
// Purpose  : Host command channel (valid/ready with PE index and configure word)
// Revision : 1.0
// ============================================================================
interface noc_config_injector_if #(
    parameter int PE_W  = 2,
    parameter int CFG_W = 11
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [PE_W-1:0]  cmd_pe;
    logic [CFG_W-1:0] cmd_cfg;

    modport master (output cmd_valid, cmd_pe, cmd_cfg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_pe, cmd_cfg, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/noc_config_injector.sv
`default_nettype none
// ============================================================================
// Module   : noc_config_injector
// Purpose  : Queues host configure commands and hands them to mesh PEs one at a time
// Revision : 1.0
// ============================================================================
module noc_config_injector #(
    parameter int NUM_PE  = 4,
    parameter int CFG_W   = 11,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    noc_config_injector_if.slave         cmd,
    output logic [NUM_PE*CFG_W-1:0]      pe_configure,
    output logic [NUM_PE-1:0]            pe_cfg_valid,
    input  wire logic [NUM_PE-1:0]       processor_ready_signals,
    output logic                         busy,
    output logic [15:0]                  done_count,
    output logic [NUM_PE-1:0]            timeout_err,
    output logic                         bad_cmd
);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [PE_W-1:0]          r_mem_pe  [DEPTH];
    logic [CFG_W-1:0]         r_mem_cfg [DEPTH];
    logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
    logic [AW:0]              r_count;
    logic [1:0]               r_state, w_next_state;
    logic [PE_W-1:0]          r_pe;
    logic [TW-1:0]            r_timer;
    logic [NUM_PE*CFG_W-1:0]  r_pe_configure;
    logic [15:0]              r_done_count;
    logic [NUM_PE-1:0]        r_timeout_err;
    logic                     r_bad_cmd;

    logic w_full, w_empty, w_in_range, w_accept, w_push, w_pop;
    logic w_done, w_expire, w_pe_ready, w_timer_hit;
    logic [PE_W-1:0]  w_head_pe;
    logic [CFG_W-1:0] w_head_cfg;

    assign w_full        = (r_count == (AW+1)'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_in_range    = (32'(cmd.cmd_pe) < NUM_PE);
    // Ready is forced low for as long as reset is held.
    assign cmd.cmd_ready = reset & ~w_full;
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;
    assign w_push        = w_accept & w_in_range;
    assign w_head_pe     = r_mem_pe[r_rd_ptr];
    assign w_head_cfg    = r_mem_cfg[r_rd_ptr];
    assign w_pe_ready    = processor_ready_signals[r_pe];
    assign w_timer_hit   = (r_timer == TW'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_pe[r_wr_ptr]  <= cmd.cmd_pe;
            r_mem_cfg[r_wr_ptr] <= cmd.cmd_cfg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!w_pe_ready) begin
                    w_next_state = S_WAIT_DONE;
                end else if (w_timer_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (w_pe_ready) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_timer_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pe_cfg_valid = '0;
        if (r_state == S_ISSUE) pe_cfg_valid[r_pe] = 1'b1;
        busy = !w_empty || (r_state != S_IDLE);
    end

    // Handshake timer spans both wait states; it restarts with every issued command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pe           <= '0;
            r_timer        <= '0;
            r_pe_configure <= '0;
            r_done_count   <= '0;
            r_timeout_err  <= '0;
            r_bad_cmd      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_pe    <= w_head_pe;
                r_timer <= '0;
                r_pe_configure[w_head_pe*CFG_W +: CFG_W] <= w_head_cfg;
            end else if ((r_state == S_WAIT_ACK || r_state == S_WAIT_DONE) && !w_timer_hit) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_done)                  r_done_count      <= r_done_count + 16'd1;
            if (w_expire)                r_timeout_err[r_pe] <= 1'b1;
            if (w_accept && !w_in_range) r_bad_cmd         <= 1'b1;
        end
    end

    assign pe_configure = r_pe_configure;
    assign done_count   = r_done_count;
    assign timeout_err  = r_timeout_err;
    assign bad_cmd      = r_bad_cmd;
endmodule
`default_nettype wire

// File: tb/tb_noc_config_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_config_injector
// Purpose  : Directed self-checking bench for noc_config_injector
// Revision : 1.0
// ============================================================================
module tb_noc_config_injector;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rdy   = 4'hF;
    logic [2:0]  rdy3  = 3'h7;

    logic [43:0] pe_configure;
    logic [3:0]  pe_cfg_valid, timeout_err;
    logic        busy, bad_cmd;
    logic [15:0] done_count;

    logic [32:0] pe_configure3;
    logic [2:0]  pe_cfg_valid3, timeout_err3;
    logic        busy3, bad_cmd3;
    logic [15:0] done_count3;

    noc_config_injector_if #(.PE_W(2), .CFG_W(11)) cif ();
    noc_config_injector_if #(.PE_W(2), .CFG_W(11)) cif3 ();

    noc_config_injector #(.NUM_PE(4), .CFG_W(11), .DEPTH(8), .TIMEOUT(255)) u_dut (
        .clock                   (clk),
        .reset                   (rst_n),
        .cmd                     (cif),
        .pe_configure            (pe_configure),
        .pe_cfg_valid            (pe_cfg_valid),
        .processor_ready_signals (rdy),
        .busy                    (busy),
        .done_count              (done_count),
        .timeout_err             (timeout_err),
        .bad_cmd                 (bad_cmd)
    );

    noc_config_injector #(.NUM_PE(3), .CFG_W(11), .DEPTH(8), .TIMEOUT(255)) u_dut3 (
        .clock                   (clk),
        .reset                   (rst_n),
        .cmd                     (cif3),
        .pe_configure            (pe_configure3),
        .pe_cfg_valid            (pe_cfg_valid3),
        .processor_ready_signals (rdy3),
        .busy                    (busy3),
        .done_count              (done_count3),
        .timeout_err             (timeout_err3),
        .bad_cmd                 (bad_cmd3)
    );

    always #5 clk = ~clk;

    // Strobe log for the 4-PE instance, sampled mid-cycle.
    logic [3:0] strobe_q [$];
    always @(negedge clk) if (pe_cfg_valid != 4'h0) strobe_q.push_back(pe_cfg_valid);

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_idx = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] pe, input logic [10:0] cfg);
        int n = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_pe    = pe;
        cif.cmd_cfg   = cfg;
        while (!cif.cmd_ready && n < 400) begin
            cyc(1);
            n++;
        end
        chk("push_ready", 64'(cif.cmd_ready), 64'd1);
        cyc(1);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_strobe(output logic [3:0] oh);
        int n = 0;
        while (strobe_q.size() <= rd_idx && n < 400) begin
            cyc(1);
            n++;
        end
        chk("strobe_seen", 64'(strobe_q.size() > rd_idx), 64'd1);
        oh = (strobe_q.size() > rd_idx) ? strobe_q[rd_idx] : 4'h0;
        rd_idx++;
    endtask

    // Model PE: go busy for one cycle after its strobe, then ready again.
    task automatic serve_one(output logic [3:0] oh);
        wait_strobe(oh);
        rdy = rdy & ~oh;
        cyc(1);
        rdy = rdy | oh;
        cyc(1);
    endtask

    initial begin
        logic [3:0] oh;
        int         base;
        int         n;

        cif.cmd_valid  = 1'b0;
        cif.cmd_pe     = 2'd0;
        cif.cmd_cfg    = 11'h0;
        cif3.cmd_valid = 1'b0;
        cif3.cmd_pe    = 2'd0;
        cif3.cmd_cfg   = 11'h0;

        // Reset state
        #1;
        chk("rst_cmd_ready", 64'(cif.cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg", 64'(pe_configure), 64'd0);
        chk("rst_done", 64'(done_count), 64'd0);
        #12 rst_n = 1'b1;
        cyc(1);
        chk("rel_cmd_ready", 64'(cif.cmd_ready), 64'd1);

        // Out-of-range PE on the 3-PE instance
        chk("bad3_init", 64'(bad_cmd3), 64'd0);
        cif3.cmd_valid = 1'b1;
        cif3.cmd_pe    = 2'd3;
        cif3.cmd_cfg   = 11'h7FF;
        cyc(1);
        cif3.cmd_valid = 1'b0;
        chk("bad3_set", 64'(bad_cmd3), 64'd1);
        chk("bad3_busy", 64'(busy3), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("bad3_nostrobe", 64'(pe_cfg_valid3), 64'd0);
        end
        cif3.cmd_valid = 1'b1;
        cif3.cmd_pe    = 2'd2;
        cif3.cmd_cfg   = 11'h055;
        cyc(1);
        cif3.cmd_valid = 1'b0;
        cyc(1);
        chk("pe3_strobe2", 64'(pe_cfg_valid3), 64'h4);
        chk("pe3_cfg2", 64'(pe_configure3[32:22]), 64'h055);
        chk("bad3_sticky", 64'(bad_cmd3), 64'd1);

        // Basic issue to PE0 with latency check
        push(2'd0, 11'h043);
        chk("lat_pre", 64'(pe_cfg_valid), 64'h0);
        chk("busy_queued", 64'(busy), 64'd1);
        cyc(1);
        chk("strobe0", 64'(pe_cfg_valid), 64'h1);
        chk("cfg0", 64'(pe_configure[10:0]), 64'h043);
        cyc(1);
        chk("strobe0_off", 64'(pe_cfg_valid), 64'h0);
        rdy[0] = 1'b0;
        cyc(5);
        chk("done_hold", 64'(done_count), 64'd0);
        rdy[0] = 1'b1;
        cyc(1);
        chk("done1", 64'(done_count), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        rd_idx = strobe_q.size();

        // Ordering across PE1..PE3
        push(2'd1, 11'h027);
        push(2'd2, 11'h081);
        push(2'd3, 11'h205);
        for (int k = 1; k < 4; k++) begin
            serve_one(oh);
            chk("order", 64'(oh), 64'(4'b0001 << k));
            chk("one_outstanding", 64'(strobe_q.size()), 64'(rd_idx));
        end
        chk("done4", 64'(done_count), 64'd4);
        chk("cfg_all", 64'(pe_configure), 64'({11'h205, 11'h081, 11'h027, 11'h043}));

        // Full FIFO: hold PE0 busy so nothing drains
        push(2'd0, 11'h111);
        wait_strobe(oh);
        rdy[0] = 1'b0;
        cyc(1);
        for (int i = 0; i < 8; i++) push(2'(i), 11'(256 + i));
        chk("full_ready", 64'(cif.cmd_ready), 64'd0);
        cif.cmd_valid = 1'b1;
        cif.cmd_pe    = 2'd1;
        cif.cmd_cfg   = 11'h3FF;
        cyc(2);
        chk("full_hold", 64'(cif.cmd_ready), 64'd0);
        rdy[0] = 1'b1;
        cyc(1);
        chk("full_at_done", 64'(cif.cmd_ready), 64'd0);
        cyc(1);
        chk("ready_after_pop", 64'(cif.cmd_ready), 64'd1);
        push(2'd1, 11'h3FF);
        for (int i = 0; i < 9; i++) serve_one(oh);
        chk("last_is_9th", 64'(oh), 64'h2);
        chk("done14", 64'(done_count), 64'd14);
        chk("cfg_full", 64'(pe_configure), 64'({11'h107, 11'h106, 11'h3FF, 11'h104}));

        // Timeout on PE2 while PE3 waits behind it
        push(2'd2, 11'h0AA);
        push(2'd3, 11'h0BB);
        wait_strobe(oh);
        chk("to_strobe", 64'(oh), 64'h4);
        base = strobe_q.size();
        cyc(200);
        chk("to_early", 64'(timeout_err), 64'h0);
        chk("to_blocked", 64'(strobe_q.size()), 64'(base));
        n = 0;
        while (timeout_err == 4'h0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("to_err", 64'(timeout_err), 64'h4);
        chk("to_done", 64'(done_count), 64'd14);
        serve_one(oh);
        chk("to_next", 64'(oh), 64'h8);
        chk("to_done_next", 64'(done_count), 64'd15);
        chk("to_sticky", 64'(timeout_err), 64'h4);

        // Reset in WAIT_DONE with three commands queued
        push(2'd1, 11'h0CC);
        wait_strobe(oh);
        rdy[1] = 1'b0;
        cyc(1);
        push(2'd0, 11'h001);
        push(2'd2, 11'h002);
        push(2'd3, 11'h003);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({pe_configure, pe_cfg_valid, done_count, timeout_err, bad_cmd, busy}), 64'd0);
        chk("mid_rst_ready", 64'(cif.cmd_ready), 64'd0);
        #3 rst_n = 1'b1;
        rdy  = 4'hF;
        base = strobe_q.size();
        cyc(20);
        chk("post_rst_nostrobe", 64'(strobe_q.size()), 64'(base));
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(cif.cmd_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/noc_config_injector.md
NOC_CONFIG_INJECTOR -- requirements
Module: noc_config_injector

Interface
REQ-001 SHALL have parameter NUM_PE, default 4: number of mesh processing elements served.
REQ-002 SHALL have parameter CFG_W, default 11: width of one configure word.
REQ-003 SHALL have parameter DEPTH, default 8: command FIFO entries, a power of two and at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles allowed for one PE handshake.
REQ-005 SHALL have derived PE_W = max(1, clog2(NUM_PE)).
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge system clock.
REQ-007 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-008 SHALL have port cmd_valid  in  1  host command present.
REQ-009 SHALL have port cmd_ready  out  1  FIFO can accept a command.
REQ-010 SHALL have port cmd_pe  in  PE_W  target PE index.
REQ-011 SHALL have port cmd_cfg  in  CFG_W  configure word.
REQ-012 SHALL have port pe_configure  out  NUM_PE*CFG_W  per-PE held configure word; PE i occupies bits [i*CFG_W +: CFG_W].
REQ-013 SHALL have port pe_cfg_valid  out  NUM_PE  one-cycle strobe per PE.
REQ-014 SHALL have port processor_ready_signals  in  NUM_PE  per-PE ready; low = busy.
REQ-015 SHALL have port busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-016 SHALL have port done_count  out  16  completed configurations.
REQ-017 SHALL have port timeout_err  out  NUM_PE  sticky per-PE timeout flags.
REQ-018 SHALL have port bad_cmd  out  1  sticky flag for out-of-range cmd_pe.

Function
REQ-019 SHALL write the command into the FIFO on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal not-full.
REQ-020 SHALL drop a command with cmd_pe >= NUM_PE at acceptance without writing the FIFO, and SHALL set bad_cmd.
REQ-021 SHALL use an FSM with states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-022 IDLE: when the FIFO is non-empty, SHALL pop the head, load pe_configure[pe] with its word, assert pe_cfg_valid[pe], and go to ISSUE.
REQ-023 ISSUE: SHALL last exactly one cycle, so pe_cfg_valid is high for one cycle only; SHALL then go to WAIT_ACK.
REQ-024 WAIT_ACK: SHALL move to WAIT_DONE when processor_ready_signals[pe] is low.
REQ-025 WAIT_DONE: when processor_ready_signals[pe] is high, SHALL increment done_count and go to IDLE.
REQ-026 SHALL keep one timeout counter that clears on entry to ISSUE and increments in WAIT_ACK/WAIT_DONE; when it reaches TIMEOUT, SHALL set timeout_err[pe], go to IDLE and not increment done_count.
REQ-027 SHALL have latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce a pe_cfg_valid pulse in the cycle after edge N+1.
REQ-028 SHALL issue commands strictly in FIFO order, one outstanding handshake at a time.
REQ-029 SHALL hold pe_configure[i] until the next command to PE i.
REQ-030 SHALL allow a simultaneous push and pop when the FIFO is not full; occupancy is then unchanged.
REQ-031 SHALL not push when full, even if a pop occurs in the same cycle.
REQ-032 SHALL let done_count wrap from 16'hFFFF to 0.
REQ-033 SHALL set busy = (FIFO non-empty) OR (state != IDLE).

Reset
REQ-034 While reset is low, SHALL asynchronously clear: FIFO pointers and occupancy to 0, FSM to IDLE, pe_configure to 0, pe_cfg_valid to 0, done_count to 0, timeout_err to 0, bad_cmd to 0 and the timeout counter to 0.
REQ-035 While reset is low, SHALL drive cmd_ready low; after release, cmd_ready SHALL be high from the first clock edge.
REQ-036 On reset asserted mid-handshake, SHALL discard the in-flight command and all queued commands.

Verification
REQ-037 SHALL cover basic issue: cmd_pe=0, cmd_cfg=11'h043, with PE0 ready dropping 2 cycles after the strobe and rising 5 cycles later -> pe_configure[10:0]=11'h043, one-cycle pe_cfg_valid[0], done_count=1, busy ends low.
REQ-038 SHALL cover ordering: push to PE1=11'h027, PE2=11'h081, PE3=11'h205 back-to-back -> strobes appear in order 1,2,3, each after the previous WAIT_DONE, and done_count=3.
REQ-039 SHALL cover full FIFO: push 9 commands with all PEs held busy -> cmd_ready goes low after 8; the 9th is accepted only after the first pop.
REQ-040 SHALL cover timeout: PE2 ready held high and never drops -> after TIMEOUT=255 cycles, timeout_err=4'b0100, done_count unchanged, and the next command issues.
REQ-041 SHALL cover out-of-range command: NUM_PE=3, cmd_pe=3 -> bad_cmd=1, FIFO occupancy unchanged, no strobe.
REQ-042 SHALL cover reset mid-op: reset low during WAIT_DONE with 3 commands queued -> all outputs 0 immediately, and no strobe after release.
